// File: rtl/arbiter_rr2.sv
// Two-way combinational grant: picks M0 or M1 from the current requests, using the
// previous grant to alternate on contention when ROUND_ROBIN is nonzero.
module arbiter_rr2 #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic m0_request,
  input  logic m1_request,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant
);

  // Grant selection: a lone requester always wins; contention goes to M0 or alternates
  always_comb begin
    grant_valid = m0_request | m1_request;
    grant       = 1'b0;
    if (m0_request && m1_request) begin
      if (ROUND_ROBIN != 0) begin
        grant = ~last_grant;
      end else begin
        grant = 1'b0;
      end
    end else if (m1_request) begin
      grant = 1'b1;
    end else begin
      grant = 1'b0;
    end
  end

endmodule

// File: rtl/video_bus_arbiter.sv
// Shares the character video device port between the CPU bus (M0) and a debug/DMA master (M1),
// sequencing one strobe/response transaction at a time with registered outputs.
module video_bus_arbiter #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_m0_request,
  input  logic        i_m0_rw,
  input  logic [31:0] i_m0_address,
  input  logic [31:0] i_m0_wdata,
  output logic [31:0] o_m0_rdata,
  output logic        o_m0_ready,
  input  logic        i_m1_request,
  input  logic        i_m1_rw,
  input  logic [31:0] i_m1_address,
  input  logic [31:0] i_m1_wdata,
  output logic [31:0] o_m1_rdata,
  output logic        o_m1_ready,
  output logic        o_video_request,
  output logic        o_video_rw,
  output logic [31:0] o_video_address,
  output logic [31:0] o_video_wdata,
  input  logic [31:0] i_video_rdata,
  output logic        o_busy
);

  localparam logic GRANT_M0 = 1'b0;
  localparam logic GRANT_M1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic        last_grant_r, last_grant_s;
  logic        active_r, active_s;
  logic        grant_valid_s, grant_s;
  logic        video_request_r, video_request_s;
  logic        video_rw_r, video_rw_s;
  logic [31:0] video_address_r, video_address_s;
  logic [31:0] video_wdata_r, video_wdata_s;
  logic [31:0] m0_rdata_r, m0_rdata_s;
  logic [31:0] m1_rdata_r, m1_rdata_s;
  logic        m0_ready_r, m0_ready_s;
  logic        m1_ready_r, m1_ready_s;
  logic        busy_r, busy_s;

  arbiter_rr2 #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_arbiter (
    .m0_request  (i_m0_request),
    .m1_request  (i_m1_request),
    .last_grant  (last_grant_r),
    .grant_valid (grant_valid_s),
    .grant       (grant_s)
  );

  // Next state and next values of every output register
  always_comb begin
    state_s         = state_r;
    last_grant_s    = last_grant_r;
    active_s        = active_r;
    video_request_s = 1'b0;
    video_rw_s      = video_rw_r;
    video_address_s = video_address_r;
    video_wdata_s   = video_wdata_r;
    m0_rdata_s      = m0_rdata_r;
    m1_rdata_s      = m1_rdata_r;
    m0_ready_s      = 1'b0;
    m1_ready_s      = 1'b0;
    busy_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (grant_valid_s) begin
          state_s         = ST_ISSUE;
          last_grant_s    = grant_s;
          active_s        = grant_s;
          video_request_s = 1'b1;
          if (grant_s == GRANT_M1) begin
            video_rw_s      = i_m1_rw;
            video_address_s = i_m1_address;
            video_wdata_s   = i_m1_wdata;
          end else begin
            video_rw_s      = i_m0_rw;
            video_address_s = i_m0_address;
            video_wdata_s   = i_m0_wdata;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_s = ST_WAIT;
      ST_WAIT: begin
        // The device registered its read data on the strobe edge, so it is valid now
        if (active_r == GRANT_M1) begin
          m1_rdata_s = i_video_rdata;
          m1_ready_s = 1'b1;
        end else begin
          m0_rdata_s = i_video_rdata;
          m0_ready_s = 1'b1;
        end
        state_s = ST_DONE;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_r         <= ST_IDLE;
      last_grant_r    <= GRANT_M1;
      active_r        <= GRANT_M0;
      video_request_r <= 1'b0;
      video_rw_r      <= 1'b0;
      video_address_r <= 32'h0000_0000;
      video_wdata_r   <= 32'h0000_0000;
      m0_rdata_r      <= 32'h0000_0000;
      m1_rdata_r      <= 32'h0000_0000;
      m0_ready_r      <= 1'b0;
      m1_ready_r      <= 1'b0;
      busy_r          <= 1'b0;
    end else begin
      state_r         <= state_s;
      last_grant_r    <= last_grant_s;
      active_r        <= active_s;
      video_request_r <= video_request_s;
      video_rw_r      <= video_rw_s;
      video_address_r <= video_address_s;
      video_wdata_r   <= video_wdata_s;
      m0_rdata_r      <= m0_rdata_s;
      m1_rdata_r      <= m1_rdata_s;
      m0_ready_r      <= m0_ready_s;
      m1_ready_r      <= m1_ready_s;
      busy_r          <= busy_s;
    end
  end

  assign o_video_request = video_request_r;
  assign o_video_rw      = video_rw_r;
  assign o_video_address = video_address_r;
  assign o_video_wdata   = video_wdata_r;
  assign o_m0_rdata      = m0_rdata_r;
  assign o_m1_rdata      = m1_rdata_r;
  assign o_m0_ready      = m0_ready_r;
  assign o_m1_ready      = m1_ready_r;
  assign o_busy          = busy_r;

endmodule
